// File: rtl/source_packetizer.sv
// rtl/source_packetizer.sv - header/port/stamp/payload flit packetizer; optional SOURCE_PKT_CHECKSUM_EN tail checksum
module source_packetizer #(
    parameter int FLIT_DATA_WIDTH = 32,
    parameter int FLIT_TYPE_WIDTH = 2,
    parameter int VCHANNELS       = 2,
    parameter int MSG_LEN_WIDTH   = 10,
    parameter int BASE_ADDR       = 40,
    localparam int VC_W           = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1,
    localparam int FLIT_W         = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH,
    localparam int ADDR_W         = MSG_LEN_WIDTH + 8
) (
    input  logic                       clk,
    input  logic                       rst_source,
    input  logic                       i_trigger,
    input  logic [VC_W-1:0]            i_vc,
    input  logic [MSG_LEN_WIDTH-1:0]   msglen,
    input  logic [FLIT_DATA_WIDTH-5:0] routing_opcode,
    input  logic [3:0]                 Tx_Traffic_id,
    input  logic [7:0]                 Dest_port_id,
    input  logic [63:0]                GTB,
    output logic                       out_rd_en,
    output logic [ADDR_W-1:0]          out_rd_addr,
    input  logic [FLIT_DATA_WIDTH-1:0] i_source_data_in,
    output logic [FLIT_W-1:0]          flit,
    output logic [VCHANNELS-1:0]       valid,
    input  logic [VCHANNELS-1:0]       ready,
    output logic                       busy,
    output logic                       done,
    output logic [31:0]                count
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HDR     = 3'd1;
    localparam logic [2:0] S_PORT    = 3'd2;
    localparam logic [2:0] S_STAMP   = 3'd3;
    localparam logic [2:0] S_PAYLOAD = 3'd4;
`ifdef SOURCE_PKT_CHECKSUM_EN
    localparam logic [2:0] S_CKSUM   = 3'd5;
`endif

    localparam logic [FLIT_TYPE_WIDTH-1:0] T_HDR  = FLIT_TYPE_WIDTH'(1);
    localparam logic [FLIT_TYPE_WIDTH-1:0] T_BODY = FLIT_TYPE_WIDTH'(0);
    localparam logic [FLIT_TYPE_WIDTH-1:0] T_TAIL = FLIT_TYPE_WIDTH'(2);

    logic [2:0]                 state_q, state_d;
    logic [VC_W-1:0]            vc_q, vc_d;
    logic [MSG_LEN_WIDTH-1:0]   len_q, len_d;
    logic [FLIT_DATA_WIDTH-1:0] stamp_q, stamp_d;
    logic [FLIT_W-1:0]          flit_q, flit_d;
    logic                       ovalid_q, ovalid_d;
    logic                       last_q, last_d;
    logic [31:0]                count_q, count_d;
    logic                       done_q, done_d;
    logic                       rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]          rd_addr_q, rd_addr_d;
    logic [MSG_LEN_WIDTH-1:0]   rd_idx_q, rd_idx_d;
    logic [MSG_LEN_WIDTH-1:0]   ld_idx_q, ld_idx_d;
    logic                       pend_q, pend_d;
    logic [FLIT_DATA_WIDTH-1:0] buf_q [2];
    logic [FLIT_DATA_WIDTH-1:0] buf_d [2];
    logic                       buf_wp_q, buf_wp_d;
    logic                       buf_rp_q, buf_rp_d;
    logic [1:0]                 buf_cnt_q, buf_cnt_d;
`ifdef SOURCE_PKT_CHECKSUM_EN
    logic [FLIT_DATA_WIDTH-1:0] csum_q, csum_d;
`endif

    logic                       xfer;
    logic                       avail;
    logic [FLIT_DATA_WIDTH-1:0] head;
    logic                       want_load;
    logic                       pop;
    logic                       read_phase;
    logic [2:0]                 occ;
    logic                       issue;
    logic                       buf_wr;
    logic                       buf_pop;
    logic                       unused_gtb;

    assign unused_gtb = ^{GTB[63:FLIT_DATA_WIDTH+6], GTB[5:0]};

    assign xfer  = ovalid_q & ready[vc_q];
    // Payload comes from the buffer head, or straight off the read bus when the buffer is empty
    assign avail = (buf_cnt_q != 2'd0) | pend_q;
    assign head  = (buf_cnt_q != 2'd0) ? buf_q[buf_rp_q] : i_source_data_in;

    assign want_load = ((state_q == S_STAMP) & xfer) |
                       ((state_q == S_PAYLOAD) & (~ovalid_q | (xfer & ~last_q)));
    assign pop       = want_load & avail;
    assign buf_wr    = pend_q & ~(pop & (buf_cnt_q == 2'd0));
    assign buf_pop   = pop & (buf_cnt_q != 2'd0);

    // Reads start once the header leaves; a word popped this cycle frees its slot immediately,
    // which is what keeps the payload back-to-back with only two slots of storage
    assign read_phase = ((state_q == S_HDR) & xfer) | (state_q == S_PORT) |
                        (state_q == S_STAMP) | (state_q == S_PAYLOAD);
    assign occ   = {1'b0, buf_cnt_q} + {2'b00, rd_en_q} + {2'b00, pend_q};
    assign issue = read_phase & (rd_idx_q < len_q) & (occ < (3'd2 + {2'b00, pop}));

    assign flit        = flit_q;
    assign valid       = ovalid_q ? (VCHANNELS'(1) << vc_q) : '0;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign count       = count_q;
    assign out_rd_en   = rd_en_q;
    assign out_rd_addr = rd_addr_q;

    // Next-state: packet sequencing, payload buffer and read scheduling
    always_comb begin
        state_d   = state_q;
        vc_d      = vc_q;
        len_d     = len_q;
        stamp_d   = stamp_q;
        flit_d    = flit_q;
        ovalid_d  = ovalid_q;
        last_d    = last_q;
        done_d    = 1'b0;
        count_d   = count_q + {31'd0, xfer};
        rd_en_d   = issue;
        rd_addr_d = rd_addr_q;
        rd_idx_d  = rd_idx_q;
        ld_idx_d  = ld_idx_q;
        pend_d    = rd_en_q;
        buf_d     = buf_q;
        buf_wp_d  = buf_wp_q;
        buf_rp_d  = buf_rp_q;
        buf_cnt_d = buf_cnt_q + {1'b0, buf_wr} - {1'b0, buf_pop};
`ifdef SOURCE_PKT_CHECKSUM_EN
        csum_d    = csum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (i_trigger && (msglen != '0)) begin
                    state_d  = S_HDR;
                    vc_d     = i_vc;
                    len_d    = msglen;
                    stamp_d  = GTB[FLIT_DATA_WIDTH+5:6];
                    flit_d   = {T_HDR, Tx_Traffic_id, routing_opcode};
                    ovalid_d = 1'b1;
                    last_d   = 1'b0;
                    count_d  = '0;
                    rd_idx_d = '0;
                    ld_idx_d = '0;
`ifdef SOURCE_PKT_CHECKSUM_EN
                    csum_d   = '0;
`endif
                end
            end
            S_HDR: begin
                if (xfer) begin
                    state_d = S_PORT;
                    flit_d  = {T_BODY, {(FLIT_DATA_WIDTH-8){1'b0}}, Dest_port_id};
                end
            end
            S_PORT: begin
                if (xfer) begin
                    state_d = S_STAMP;
                    flit_d  = {T_BODY, stamp_q};
                end
            end
            S_STAMP: begin
                if (xfer) begin
                    state_d  = S_PAYLOAD;
                    ovalid_d = 1'b0;
                end
            end
            S_PAYLOAD: begin
                if (xfer) begin
                    if (last_q) begin
`ifdef SOURCE_PKT_CHECKSUM_EN
                        state_d = S_CKSUM;
                        flit_d  = {T_TAIL, csum_q};
`else
                        state_d  = S_IDLE;
                        ovalid_d = 1'b0;
                        done_d   = 1'b1;
                        flit_d   = '0;
`endif
                    end else begin
                        ovalid_d = 1'b0;
                    end
                end
            end
`ifdef SOURCE_PKT_CHECKSUM_EN
            S_CKSUM: begin
                if (xfer) begin
                    state_d  = S_IDLE;
                    ovalid_d = 1'b0;
                    done_d   = 1'b1;
                    flit_d   = '0;
                end
            end
`endif
            default: begin
                state_d  = S_IDLE;
                ovalid_d = 1'b0;
            end
        endcase

        if (pop) begin
`ifdef SOURCE_PKT_CHECKSUM_EN
            flit_d = {T_BODY, head};
            csum_d = csum_q ^ head;
`else
            flit_d = {(ld_idx_q == len_q - 1'b1) ? T_TAIL : T_BODY, head};
`endif
            last_d   = (ld_idx_q == len_q - 1'b1);
            ld_idx_d = ld_idx_q + 1'b1;
            ovalid_d = 1'b1;
        end

        if (issue) begin
            rd_addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(rd_idx_q);
            rd_idx_d  = rd_idx_q + 1'b1;
        end

        if (buf_wr) begin
            buf_d[buf_wp_q] = i_source_data_in;
            buf_wp_d        = ~buf_wp_q;
        end
        if (buf_pop) begin
            buf_rp_d = ~buf_rp_q;
        end
    end

    // State registers; reset aborts any packet and drops in-flight read data
    always_ff @(posedge clk) begin
        if (rst_source) begin
            state_q   <= S_IDLE;
            vc_q      <= '0;
            len_q     <= '0;
            stamp_q   <= '0;
            flit_q    <= '0;
            ovalid_q  <= 1'b0;
            last_q    <= 1'b0;
            count_q   <= '0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_idx_q  <= '0;
            ld_idx_q  <= '0;
            pend_q    <= 1'b0;
            buf_q     <= '{default: '0};
            buf_wp_q  <= 1'b0;
            buf_rp_q  <= 1'b0;
            buf_cnt_q <= '0;
`ifdef SOURCE_PKT_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            vc_q      <= vc_d;
            len_q     <= len_d;
            stamp_q   <= stamp_d;
            flit_q    <= flit_d;
            ovalid_q  <= ovalid_d;
            last_q    <= last_d;
            count_q   <= count_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            rd_idx_q  <= rd_idx_d;
            ld_idx_q  <= ld_idx_d;
            pend_q    <= pend_d;
            buf_q     <= buf_d;
            buf_wp_q  <= buf_wp_d;
            buf_rp_q  <= buf_rp_d;
            buf_cnt_q <= buf_cnt_d;
`ifdef SOURCE_PKT_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

endmodule
